// File: rtl/dff8_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// dff8_write_arbiter_if
// Bundles the requester-side handshake and the exported register view of the
// shared write arbiter.
//   req_valid    : per-requester write pending
//   req_data     : packed write data, requester i owns bits [WIDTH*i +: WIDTH]
//   req_hold     : per-requester request to keep ownership after a grant
//   req_ready    : one-hot or zero acceptance strobe from the arbiter
//   q            : registered bank value
//   grant_id     : index of the last accepted writer
//   write_strobe : one-cycle pulse after each accepted write
//   busy         : high while a requester owns the bank
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface dff8_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_hold;
   logic [NUM_REQ-1:0]       req_ready;
   logic [WIDTH-1:0]         q;
   logic [ID_W-1:0]          grant_id;
   logic                     write_strobe;
   logic                     busy;

   modport master (
      output req_valid, req_data, req_hold,
      input  req_ready, q, grant_id, write_strobe, busy
   );

   modport slave (
      input  req_valid, req_data, req_hold,
      output req_ready, q, grant_id, write_strobe, busy
   );
endinterface

// File: rtl/dff8_write_arbiter.sv
// ---------------------------------------------------------------------------
// dff8_write_arbiter
// One WIDTH-bit register shared by NUM_REQ requesters. Writes are granted
// round-robin; a winner asserting hold keeps exclusive ownership for at most
// MAX_HOLD consecutive cycles (the grant cycle counts as the first).
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high, overrides everything
//   bus   : dff8_write_arbiter_if.slave (handshake + exported register view)
// ---------------------------------------------------------------------------
module dff8_write_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   dff8_write_arbiter_if.slave   bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic              strobe_q;
   logic              busy_q;

   logic [NUM_REQ-1:0] ready;
   logic               accept;
   logic [ID_W-1:0]    win;
   logic               continuing;
   logic [ID_W:0]      pick;
   logic [WIDTH-1:0]   data_arr [NUM_REQ];

   // Increment modulo NUM_REQ; explicit wrap keeps non-power-of-2 counts legal.
   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
      if (i == ID_W'(NUM_REQ - 1)) return '0;
      return i + ID_W'(1);
   endfunction

   // Returns {found, index} of the first valid requester at or after ptr.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [ID_W-1:0]    ptr);
      logic [ID_W:0]   res;
      logic [ID_W-1:0] idx;
      res = '0;
      idx = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!res[ID_W] && vld[idx]) res = {1'b1, idx};
         idx = wrap_inc(idx);
      end
      return res;
   endfunction

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = bus.req_data[g*WIDTH +: WIDTH];
   end

   assign pick       = rr_pick(bus.req_valid, rr_ptr_q);
   assign continuing = (state_q == OWNED) && bus.req_hold[owner_q] && (cnt_q < HOLD_MAX);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      data_d   = data_q;
      grant_d  = grant_q;
      ready    = '0;
      accept   = 1'b0;
      win      = '0;

      if (continuing) begin
         // The owner is the only candidate; an idle owner still burns budget.
         cnt_d = cnt_q + CNT_ONE;
         if (bus.req_valid[owner_q]) begin
            accept = 1'b1;
            win    = owner_q;
         end
      end else begin
         // Fresh round-robin decision; an ex-owner sits last behind rr_ptr.
         state_d = IDLE;
         cnt_d   = '0;
         if (pick[ID_W]) begin
            accept = 1'b1;
            win    = pick[ID_W-1:0];
            if (bus.req_hold[pick[ID_W-1:0]] && (MAX_HOLD > 1)) begin
               state_d = OWNED;
               owner_d = pick[ID_W-1:0];
               cnt_d   = CNT_ONE;
            end
         end
      end

      if (accept) begin
         ready[win] = 1'b1;
         rr_ptr_d   = wrap_inc(win);
         grant_d    = win;
         data_d     = data_arr[win];
      end

      if (reset) ready = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
         data_q   <= '0;
         grant_q  <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         data_q   <= data_d;
         grant_q  <= grant_d;
         strobe_q <= accept;
         busy_q   <= (state_d == OWNED);
      end
   end

   assign bus.req_ready    = ready;
   assign bus.q            = data_q;
   assign bus.grant_id     = grant_q;
   assign bus.write_strobe = strobe_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_dff8_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff8_write_arbiter
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model of the ownership / round-robin rules.
// ---------------------------------------------------------------------------
module tb_dff8_write_arbiter;
   localparam int NUM_REQ  = 4;
   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;
   localparam int ID_W     = $clog2(NUM_REQ);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dff8_write_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

   dff8_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // stimulus
   logic [NUM_REQ-1:0] valid;
   logic [NUM_REQ-1:0] hold;
   logic [WIDTH-1:0]   data [NUM_REQ];

   // model state
   int m_q      = 0;
   int m_gid    = 0;
   int m_strobe = 0;
   int m_busy   = 0;
   int m_ptr    = 0;
   int m_owner  = -1;
   int m_used   = 0;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, obs, obs, exp, exp, $time);
      end
   endtask

   task automatic apply();
      bus.req_valid = valid;
      bus.req_hold  = hold;
      for (int g = 0; g < NUM_REQ; g++) bus.req_data[g*WIDTH +: WIDTH] = data[g];
   endtask

   // Who may write this cycle, and whether an owner is still holding.
   function automatic void decide(output int w, output bit excl);
      logic [ID_W-1:0] oi;
      w    = -1;
      excl = 1'b0;
      if (reset) return;
      oi = m_owner[ID_W-1:0];
      if (m_owner >= 0 && hold[oi] && m_used < MAX_HOLD) begin
         excl = 1'b1;
         if (valid[oi]) w = m_owner;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (w < 0 && valid[i[ID_W-1:0]]) w = i;
         end
      end
   endfunction

   function automatic int expected_ready();
      int  w;
      bit  excl;
      decide(w, excl);
      return (w >= 0) ? (1 << w) : 0;
   endfunction

   function automatic void model_update();
      int w;
      bit excl;
      decide(w, excl);
      if (reset) begin
         m_q = 0; m_gid = 0; m_strobe = 0; m_busy = 0;
         m_ptr = 0; m_owner = -1; m_used = 0;
         return;
      end
      if (excl) m_used++;
      else if (w >= 0 && hold[w[ID_W-1:0]] && MAX_HOLD > 1) begin
         m_owner = w;
         m_used  = 1;
      end else begin
         m_owner = -1;
         m_used  = 0;
      end
      if (w >= 0) begin
         m_q      = int'(data[w[ID_W-1:0]]);
         m_gid    = w;
         m_strobe = 1;
         m_ptr    = (w + 1) % NUM_REQ;
      end else m_strobe = 0;
      m_busy = (m_owner >= 0) ? 1 : 0;
   endfunction

   // One clock: check ready mid-cycle, then the registered outputs after the edge.
   task automatic step();
      apply();
      #1;
      check("ready", int'(bus.req_ready), expected_ready());
      @(posedge clk);
      model_update();
      #1;
      check("q",      int'(bus.q),            m_q);
      check("strobe", int'(bus.write_strobe), m_strobe);
      check("gid",    int'(bus.grant_id),     m_gid);
      check("busy",   int'(bus.busy),         m_busy);
   endtask

   initial begin
      reset = 1'b1;
      valid = '1;
      hold  = '0;
      for (int g = 0; g < NUM_REQ; g++) data[g] = 8'hAA;
      apply();
      @(posedge clk);
      #1;

      // Reset with every requester valid
      for (int c = 0; c < 2; c++) begin
         step();
         check("rst_ready", int'(bus.req_ready), 0);
         check("rst_q", int'(bus.q), 0);
         check("rst_strobe", int'(bus.write_strobe), 0);
      end
      reset = 1'b0;
      for (int g = 0; g < NUM_REQ; g++) data[g] = 8'(8'h01 + g);
      step();
      check("post_rst_gid", int'(bus.grant_id), 0);
      check("post_rst_q", int'(bus.q), 8'h01);

      // Round-robin fairness: ptr is 1 now, realign with one idle cycle each
      valid = '0;
      step();
      for (int g = 0; g < NUM_REQ; g++) data[g] = 8'(8'h11 * (g + 1));
      valid = 4'b1110;
      for (int c = 0; c < 3; c++) step();     // grants 1,2,3 -> ptr back to 0
      valid = '1;
      for (int c = 0; c < 8; c++) begin
         step();
         check("rr_gid", int'(bus.grant_id), c % 4);
         check("rr_q", int'(bus.q), 8'h11 * (c % 4 + 1));
         check("rr_strobe", int'(bus.write_strobe), 1);
      end

      // Burst limit: requester 2 holds, requester 1 waits
      valid = 4'b0100; hold = 4'b0100;
      step();
      valid = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         step();
         check("burst_gid", int'(bus.grant_id), 2);
         check("burst_busy", int'(bus.busy), 1);
      end
      step();
      check("burst_rel_gid", int'(bus.grant_id), 1);
      check("burst_rel_busy", int'(bus.busy), 0);
      valid = '0; hold = '0;
      step();

      // Idle owner stall: requester 3 grabs, then goes quiet but keeps hold
      valid = 4'b1000; hold = 4'b1000; data[3] = 8'h5C;
      step();
      valid = 4'b0001; data[0] = 8'hE7;
      for (int c = 0; c < MAX_HOLD - 1; c++) begin
         apply();
         #1;
         check("stall_ready", int'(bus.req_ready), 0);
         step();
         check("stall_q", int'(bus.q), 8'h5C);
      end
      step();
      check("stall_rel_gid", int'(bus.grant_id), 0);
      check("stall_rel_q", int'(bus.q), 8'hE7);
      valid = '0; hold = '0;
      step();

      // Early release: owner 2 drops hold on its second cycle
      valid = 4'b0100; hold = 4'b0100;
      step();
      valid = 4'b0110; hold = 4'b0000;
      apply();
      #1;
      check("early_ready", int'(bus.req_ready), 4'b0010);
      step();
      check("early_gid", int'(bus.grant_id), 1);
      check("early_busy", int'(bus.busy), 0);
      // Same again with requester 1 taking ownership
      valid = 4'b0100; hold = 4'b0100;
      step();
      valid = 4'b0110; hold = 4'b0010;
      step();
      check("early_hold_busy", int'(bus.busy), 1);
      valid = '0; hold = '0;
      step();

      // Reset mid-burst at hold_cnt == 2
      valid = 4'b1000; hold = 4'b1000;
      step();
      step();
      reset = 1'b1;
      step();
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_q", int'(bus.q), 0);
      reset = 1'b0;
      valid = 4'b1001;
      step();
      check("midrst_first_gid", int'(bus.grant_id), 0);

      // Randomized traffic with occasional resets
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 49) == 0);
         valid = NUM_REQ'($urandom);
         hold  = NUM_REQ'($urandom);
         for (int g = 0; g < NUM_REQ; g++) data[g] = WIDTH'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
